// File: rtl/MMIO_pkg.sv
// Shared types and constants for the MMIO bus fabric.
//   mmio_fsm_state_t : fabric FSM state, also exported on state_out for debug
//   MMIO_ERR_RD_BIT  : fill bit replicated across RD when a read ends in error
//   mmio_idx_w()     : width of a slave index for a given slave count
package MMIO_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } mmio_fsm_state_t;

  // A failed read returns this bit in every RD position (all ones).
  localparam logic MMIO_ERR_RD_BIT = 1'b1;

  // A single slave still needs a 1-bit index so that port widths stay legal.
  function automatic int unsigned mmio_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : MMIO_pkg

// File: rtl/mmio_addr_decoder.sv
// Combinational address decoder for the MMIO fabric.
// Slave i matches when (addr & SLAVE_MASK[i]) == SLAVE_BASE[i]; when several
// match, the lowest index wins.
//   addr : core address to decode
//   hit  : at least one slave matched
//   idx  : index of the winning slave (0 when hit is low)
module mmio_addr_decoder
  import MMIO_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned IDX_W      = 2,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // Scan from the top index down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule : mmio_addr_decoder

// File: rtl/mmio_bus_fabric.sv
// Single-master MMIO fabric: decodes a core read/write onto one of NUM_SLAVES
// peripheral channels, waits for the slave's completion with a timeout, and
// returns a one-cycle ready pulse (with bus_err on decode miss or timeout).
//   clk, rst           : clock, synchronous active-high reset
//   re, we, A, WD      : core request (re and we together count as a write)
//   RD, ready, bus_err : registered response; bus_err qualifies ready
//   busy               : transaction in flight
//   s_sel, s_we        : one-hot slave select / write enable (ACCESS only)
//   s_addr, s_wd       : latched address and write data broadcast to slaves
//   s_rd, s_ready      : per-slave read data and completion
//   state_out          : debug view of the FSM state
module mmio_bus_fabric
  import MMIO_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             re,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            A,
  input  logic [DATA_WIDTH-1:0]            WD,
  output logic [DATA_WIDTH-1:0]            RD,
  output logic                             ready,
  output logic                             busy,
  output logic                             bus_err,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [NUM_SLAVES-1:0]            s_we,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wd,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output mmio_fsm_state_t                  state_out
);

  localparam int unsigned IDX_W = mmio_idx_w(NUM_SLAVES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mmio_fsm_state_t        r_state;
  logic [DATA_WIDTH-1:0]  r_rd;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_bus_err;
  logic [NUM_SLAVES-1:0]  r_sel;
  logic [NUM_SLAVES-1:0]  r_s_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wd;
  logic                   r_we;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_dec_hit;
  logic [IDX_W-1:0]       w_dec_idx;
  logic [NUM_SLAVES-1:0]  w_dec_onehot;
  logic [DATA_WIDTH-1:0]  w_slv_rd;
  logic                   w_slv_ready;
  logic                   w_timeout;

  mmio_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr (A),
    .hit  (w_dec_hit),
    .idx  (w_dec_idx)
  );

  assign w_dec_onehot = NUM_SLAVES'(1) << w_dec_idx;
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Only the latched slave's data and completion are observed.
  always_comb begin
    w_slv_rd    = '0;
    w_slv_ready = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_slv_rd    = s_rd[i*DATA_WIDTH +: DATA_WIDTH];
        w_slv_ready = s_ready[i];
      end
    end
  end

  // Fabric FSM; every output is registered and set on the transition into
  // the state that presents it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd      <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_bus_err <= 1'b0;
      r_sel     <= '0;
      r_s_we    <= '0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_we      <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      r_ready   <= 1'b0;
      r_bus_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (re || we) begin
            r_addr <= A;
            r_wd   <= WD;
            r_we   <= we;
            r_idx  <= w_dec_idx;
            r_busy <= 1'b1;
            if (w_dec_hit) begin
              r_state <= ACCESS;
              r_cnt   <= '0;
              r_sel   <= w_dec_onehot;
              r_s_we  <= we ? w_dec_onehot : '0;
            end else begin
              // Decode miss: no slave is ever selected.
              r_state   <= ERR;
              r_ready   <= 1'b1;
              r_bus_err <= 1'b1;
              if (!we) r_rd <= {DATA_WIDTH{MMIO_ERR_RD_BIT}};
            end
          end
        end
        ACCESS: begin
          // Completion wins over a timeout landing in the same cycle.
          if (w_slv_ready) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_sel   <= '0;
            r_s_we  <= '0;
            if (!r_we) r_rd <= w_slv_rd;
          end else if (w_timeout) begin
            r_state   <= ERR;
            r_ready   <= 1'b1;
            r_bus_err <= 1'b1;
            r_sel     <= '0;
            r_s_we    <= '0;
            if (!r_we) r_rd <= {DATA_WIDTH{MMIO_ERR_RD_BIT}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP, ERR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_sel   <= '0;
          r_s_we  <= '0;
        end
      endcase
    end
  end

  assign RD        = r_rd;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign bus_err   = r_bus_err;
  assign s_sel     = r_sel;
  assign s_we      = r_s_we;
  assign s_addr    = r_addr;
  assign s_wd      = r_wd;
  assign state_out = r_state;

endmodule : mmio_bus_fabric

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: directed and randomized
// transactions against a transaction-level reference model.
module tb_mmio_bus_fabric;
  import MMIO_pkg::*;

  localparam int unsigned NS = 3;
  localparam int unsigned TO = 8;

  // Reference address map, slave 0 first.
  localparam logic [31:0] BASE_T [NS] = '{32'h0040_0000, 32'h1001_0000, 32'h1001_0024};
  localparam logic [31:0] MASK_T [NS] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FFFC};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 re, we;
  logic [31:0]          A, WD, RD;
  logic                 ready, busy, bus_err;
  logic [NS-1:0]        s_sel, s_we, s_ready;
  logic [31:0]          s_addr, s_wd;
  logic [NS*32-1:0]     s_rd;
  mmio_fsm_state_t      state_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  mmio_bus_fabric #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO),
    .SLAVE_BASE     ({32'h1001_0024, 32'h1001_0000, 32'h0040_0000}),
    .SLAVE_MASK     ({32'hFFFF_FFFC, 32'hFFFF_FF00, 32'hFFFF_FF00})
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .we        (we),
    .A         (A),
    .WD        (WD),
    .RD        (RD),
    .ready     (ready),
    .busy      (busy),
    .bus_err   (bus_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wd      (s_wd),
    .s_rd      (s_rd),
    .s_ready   (s_ready),
    .state_out (state_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First entry of the map that contains the address.
  function automatic void model_decode(input logic [31:0] a, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < int'(NS); i++) begin
      if (!hit && ((a & MASK_T[i]) == BASE_T[i])) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endfunction

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, ".state"},   32'(state_out), 32'(IDLE));
    check_eq({pfx, ".RD"},      RD,             32'h0);
    check_eq({pfx, ".ready"},   32'(ready),     32'h0);
    check_eq({pfx, ".bus_err"}, 32'(bus_err),   32'h0);
    check_eq({pfx, ".busy"},    32'(busy),      32'h0);
    check_eq({pfx, ".s_sel"},   32'(s_sel),     32'h0);
    check_eq({pfx, ".s_we"},    32'(s_we),      32'h0);
    check_eq({pfx, ".s_addr"},  s_addr,         32'h0);
    check_eq({pfx, ".s_wd"},    s_wd,           32'h0);
  endtask

  // One transaction, entered and left at a negedge with the fabric idle.
  // lat = number of ACCESS cycles before the selected slave raises s_ready.
  task automatic run_txn(input bit rq, input bit wq, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata,
                         input int lat, input bit noise);
    bit          hit;
    int          idx;
    int          edges;
    bit          err;
    logic [NS-1:0] oh;
    model_decode(addr, hit, idx);
    if (!hit) begin
      edges = 1; err = 1'b1;
    end else if (lat < int'(TO)) begin
      edges = lat + 2; err = 1'b0;
    end else begin
      edges = int'(TO) + 1; err = 1'b1;
    end
    oh = hit ? NS'(1 << idx) : '0;
    if (!wq) exp_rd = err ? 32'hFFFF_FFFF : rdata;

    re = rq; we = wq; A = addr; WD = wd;
    s_rd = {$urandom, $urandom, $urandom};
    if (hit) s_rd[idx*32 +: 32] = rdata;
    s_ready = NS'($urandom) & ~oh;

    for (int k = 1; k <= edges + 1; k++) begin
      @(negedge clk);
      if (k < edges) begin
        check_eq("acc.state", 32'(state_out), 32'(ACCESS));
        check_eq("acc.s_sel", 32'(s_sel), 32'(oh));
        check_eq("acc.s_we",  32'(s_we),  wq ? 32'(oh) : 32'h0);
        check_eq("acc.s_addr", s_addr, addr);
        check_eq("acc.s_wd",   s_wd,   wd);
        check_eq("acc.ready", 32'(ready), 32'h0);
        check_eq("acc.busy",  32'(busy),  32'h1);
      end else if (k == edges) begin
        check_eq("done.state",   32'(state_out), err ? 32'(ERR) : 32'(RESP));
        check_eq("done.ready",   32'(ready),   32'h1);
        check_eq("done.bus_err", 32'(bus_err), 32'(err));
        check_eq("done.RD",      RD,           exp_rd);
        check_eq("done.s_sel",   32'(s_sel),   32'h0);
        check_eq("done.s_we",    32'(s_we),    32'h0);
        check_eq("done.busy",    32'(busy),    32'h1);
      end else begin
        check_eq("idle.state",   32'(state_out), 32'(IDLE));
        check_eq("idle.ready",   32'(ready),   32'h0);
        check_eq("idle.bus_err", 32'(bus_err), 32'h0);
        check_eq("idle.busy",    32'(busy),    32'h0);
        check_eq("idle.RD",      RD,           exp_rd);
      end
      // Inputs for the next edge; requests during a busy transaction must be ignored.
      re = 1'b0; we = 1'b0; A = $urandom; WD = $urandom;
      if (noise && k < edges) begin
        re = 1'($urandom); we = 1'($urandom);
      end
      s_ready = (NS'($urandom) & ~oh) | ((hit && k >= lat + 1) ? oh : '0);
    end
    s_ready = '0;
  endtask

  // Reset during ACCESS aborts the access with no ready pulse.
  task automatic reset_mid(input logic [31:0] addr);
    bit hit;
    int idx;
    model_decode(addr, hit, idx);
    re = 1'b1; we = 1'b0; A = addr; WD = $urandom; s_ready = '0;
    @(negedge clk);
    re = 1'b0;
    @(negedge clk);
    check_eq("rstmid.pre_state", 32'(state_out), 32'(ACCESS));
    check_eq("rstmid.pre_sel",   32'(s_sel), hit ? 32'(1 << idx) : 32'h0);
    re = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rstmid");
    rst = 1'b0; re = 1'b0;
    exp_rd = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rstmid.no_ready", 32'(ready), 32'h0);
      check_eq("rstmid.no_busy",  32'(busy),  32'h0);
    end
  endtask

  initial begin
    int sel;
    int kind;
    logic [31:0] addr;
    rst = 1'b1; re = 1'b0; we = 1'b0; A = '0; WD = '0; s_rd = '0; s_ready = '0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Read of slave 0, completion in the first ACCESS cycle.
    run_txn(1'b1, 1'b0, 32'h0040_0008, 32'h0, 32'h0051_0113, 0, 1'b0);
    // 0x1001_0024 also sits inside slave 1's window; the lower index takes it.
    run_txn(1'b0, 1'b1, 32'h1001_0024, 32'h0000_00A5, 32'h0, 2, 1'b0);
    // Unmapped read.
    run_txn(1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'h1234_5678, 0, 1'b0);
    // Write to a slave that never answers: timeout, s_we dropped on ERR.
    run_txn(1'b0, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 32'h0, 100, 1'b0);
    // Read timeout.
    run_txn(1'b1, 1'b0, 32'h0040_00F0, 32'h0, 32'h0, int'(TO), 1'b0);
    // Completion in the last ACCESS cycle beats the timeout.
    run_txn(1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'hCAFE_0001, int'(TO) - 1, 1'b1);
    // re and we together act as a write; RD keeps its value.
    run_txn(1'b1, 1'b1, 32'h0040_0010, 32'h0000_5555, 32'hFFFF_0000, 1, 1'b1);
    // Unmapped write leaves RD alone.
    run_txn(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0, 0, 1'b0);
    // Extra re pulses while busy.
    run_txn(1'b1, 1'b0, 32'h1001_0080, 32'h0, 32'h0BAD_F00D, 4, 1'b1);

    reset_mid(32'h1001_0040);

    for (int t = 0; t < 40; t++) begin
      sel  = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 2));
      case (sel)
        0:       addr = 32'h0040_0000 | 32'($urandom_range(0, 255));
        1:       addr = 32'h1001_0000 | 32'($urandom_range(0, 255));
        2:       addr = 32'h1001_0024 | 32'($urandom_range(0, 3));
        default: addr = $urandom;
      endcase
      run_txn(kind != 1, kind != 0, addr, $urandom, $urandom,
              int'($urandom_range(0, 10)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mmio_bus_fabric
